// File: rtl/pe_pass_sequencer_if.sv
// Control bundle between the PE pass sequencer, its host config port and the conv datapath.
// master: sequencer side; slave: host/datapath side.
interface pe_pass_sequencer_if #(
  parameter int unsigned FILT_ADDR_LEN = 4,
  parameter int unsigned IF_ADDR_LEN   = 5,
  parameter int unsigned WIN_CNT_W     = 8
);
  logic                     start;
  logic [FILT_ADDR_LEN-1:0] cfg_filt_len;
  logic [IF_ADDR_LEN-1:0]   cfg_stride;
  logic                     cfg_two_filt;
  logic                     mac_fire;
  logic                     psum_done;
  logic                     full_done;
  logic                     psum_in_valid;

  logic [FILT_ADDR_LEN-1:0] filt_len;
  logic [IF_ADDR_LEN-1:0]   stride_len;
  logic                     IF_read_start;
  logic                     filter_read_start;
  logic                     start_rd_gen;
  logic                     regs_clr;
  logic                     reset_Filter;
  logic                     usage_stride_pos_ld;
  logic                     filter_mux_sel;
  logic                     reset_accumulation;
  logic                     accumulate_input_psum;
  logic [WIN_CNT_W-1:0]     win_count;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, cfg_filt_len, cfg_stride, cfg_two_filt,
    input  mac_fire, psum_done, full_done, psum_in_valid,
    output filt_len, stride_len, IF_read_start, filter_read_start,
    output start_rd_gen, regs_clr, reset_Filter, usage_stride_pos_ld,
    output filter_mux_sel, reset_accumulation, accumulate_input_psum,
    output win_count, busy, done
  );

  modport slave (
    output start, cfg_filt_len, cfg_stride, cfg_two_filt,
    output mac_fire, psum_done, full_done, psum_in_valid,
    input  filt_len, stride_len, IF_read_start, filter_read_start,
    input  start_rd_gen, regs_clr, reset_Filter, usage_stride_pos_ld,
    input  filter_mux_sel, reset_accumulation, accumulate_input_psum,
    input  win_count, busy, done
  );
endinterface

// File: rtl/pe_pass_sequencer.sv
// PE convolution pass sequencer: runs one or two filter passes over an IF row and drives datapath controls.
// Optional PSUM_CHAIN_EN: first MAC of each window may add an external partial sum.
module pe_pass_sequencer #(
  parameter int unsigned FILT_ADDR_LEN = 4,
  parameter int unsigned IF_ADDR_LEN   = 5,
  parameter int unsigned WIN_CNT_W     = 8
) (
  input logic                 clk,
  input logic                 rst,
  pe_pass_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN0,
    S_SWITCH,
    S_RUN1,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     w_cfg_ld;
  logic                     w_in_run;
  logic                     w_run_entry;

  logic [FILT_ADDR_LEN-1:0] r_filt_len;
  logic [IF_ADDR_LEN-1:0]   r_stride_len;
  logic                     r_two_filt;
  logic [WIN_CNT_W-1:0]     r_win_count;
  logic                     r_first_mac;

  logic r_if_read_start;
  logic r_filter_read_start;
  logic r_start_rd_gen;
  logic r_regs_clr;
  logic r_reset_filter;
  logic r_usage_stride_pos_ld;
  logic r_filter_mux_sel;
  logic r_busy;
  logic r_done;

  logic w_if_read_start_nxt;
  logic w_filter_read_start_nxt;
  logic w_start_rd_gen_nxt;
  logic w_regs_clr_nxt;
  logic w_reset_filter_nxt;
  logic w_usage_stride_pos_ld_nxt;
  logic w_filter_mux_sel_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;
  logic w_acc_input_psum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs are decoded from the next state so each pulse lines up with its state cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.cfg_filt_len != '0)) begin
          w_state_nxt = S_CLR;
          w_cfg_ld    = 1'b1;
        end
      end
      S_CLR:    w_state_nxt = S_RUN0;
      S_RUN0: begin
        if (bus.full_done) begin
          w_state_nxt = r_two_filt ? S_SWITCH : S_FIN;
        end
      end
      S_SWITCH: w_state_nxt = S_RUN1;
      S_RUN1: begin
        if (bus.full_done) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    w_in_run    = (r_state == S_RUN0) || (r_state == S_RUN1);
    w_run_entry = ((w_state_nxt == S_RUN0) && (r_state != S_RUN0)) ||
                  ((w_state_nxt == S_RUN1) && (r_state != S_RUN1));

    w_regs_clr_nxt            = (w_state_nxt == S_CLR);
    w_if_read_start_nxt       = (w_state_nxt == S_CLR);
    w_filter_read_start_nxt   = (w_state_nxt == S_CLR);
    w_reset_filter_nxt        = (w_state_nxt == S_CLR) || (w_state_nxt == S_SWITCH);
    w_usage_stride_pos_ld_nxt = (w_state_nxt == S_SWITCH);
    w_start_rd_gen_nxt        = w_run_entry;
    w_filter_mux_sel_nxt      = (w_state_nxt == S_RUN1);
    w_busy_nxt                = (w_state_nxt != S_IDLE);
    w_done_nxt                = (w_state_nxt == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt_len            <= '0;
      r_stride_len          <= '0;
      r_two_filt            <= 1'b0;
      r_win_count           <= '0;
      r_first_mac           <= 1'b0;
      r_if_read_start       <= 1'b0;
      r_filter_read_start   <= 1'b0;
      r_start_rd_gen        <= 1'b0;
      r_regs_clr            <= 1'b0;
      r_reset_filter        <= 1'b0;
      r_usage_stride_pos_ld <= 1'b0;
      r_filter_mux_sel      <= 1'b0;
      r_busy                <= 1'b0;
      r_done                <= 1'b0;
    end else begin
      if (w_cfg_ld) begin
        r_filt_len   <= bus.cfg_filt_len;
        r_stride_len <= bus.cfg_stride;
        r_two_filt   <= bus.cfg_two_filt;
      end

      if (w_cfg_ld) begin
        r_win_count <= '0;
      end else if (w_in_run && bus.psum_done) begin
        r_win_count <= r_win_count + WIN_CNT_W'(1);
      end

      // A window boundary re-arms first_mac even if a MAC fires in the same cycle.
      if (w_run_entry || (w_in_run && bus.psum_done)) begin
        r_first_mac <= 1'b1;
      end else if (w_in_run && bus.mac_fire) begin
        r_first_mac <= 1'b0;
      end

      r_if_read_start       <= w_if_read_start_nxt;
      r_filter_read_start   <= w_filter_read_start_nxt;
      r_start_rd_gen        <= w_start_rd_gen_nxt;
      r_regs_clr            <= w_regs_clr_nxt;
      r_reset_filter        <= w_reset_filter_nxt;
      r_usage_stride_pos_ld <= w_usage_stride_pos_ld_nxt;
      r_filter_mux_sel      <= w_filter_mux_sel_nxt;
      r_busy                <= w_busy_nxt;
      r_done                <= w_done_nxt;
    end
  end

`ifdef PSUM_CHAIN_EN
  assign w_acc_input_psum = r_first_mac && bus.psum_in_valid && w_in_run;
`else
  logic w_unused_psum_in_valid;
  assign w_unused_psum_in_valid = bus.psum_in_valid;
  assign w_acc_input_psum       = 1'b0;
`endif

  assign bus.reset_accumulation    = r_busy && (!r_first_mac || w_acc_input_psum);
  assign bus.accumulate_input_psum = w_acc_input_psum;

  assign bus.filt_len            = r_filt_len;
  assign bus.stride_len          = r_stride_len;
  assign bus.IF_read_start       = r_if_read_start;
  assign bus.filter_read_start   = r_filter_read_start;
  assign bus.start_rd_gen        = r_start_rd_gen;
  assign bus.regs_clr            = r_regs_clr;
  assign bus.reset_Filter        = r_reset_filter;
  assign bus.usage_stride_pos_ld = r_usage_stride_pos_ld;
  assign bus.filter_mux_sel      = r_filter_mux_sel;
  assign bus.win_count           = r_win_count;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;

endmodule

// File: tb/tb_pe_pass_sequencer.sv
// Directed bench for pe_pass_sequencer: one/two filter jobs, accumulation select, edge cases, reset abort.
module tb_pe_pass_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pe_pass_sequencer_if #(.FILT_ADDR_LEN(4), .IF_ADDR_LEN(5), .WIN_CNT_W(8)) bus ();

  pe_pass_sequencer #(.FILT_ADDR_LEN(4), .IF_ADDR_LEN(5), .WIN_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] len, input logic [4:0] stride, input logic two);
    bus.start        = 1'b1;
    bus.cfg_filt_len = len;
    bus.cfg_stride   = stride;
    bus.cfg_two_filt = two;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.cfg_filt_len  = '0;
    bus.cfg_stride    = '0;
    bus.cfg_two_filt  = 1'b0;
    bus.mac_fire      = 1'b0;
    bus.psum_done     = 1'b0;
    bus.full_done     = 1'b0;
    bus.psum_in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_win", 32'(bus.win_count), 0);
    check("rst_filt_len", 32'(bus.filt_len), 0);
    check("rst_stride", 32'(bus.stride_len), 0);
    check("rst_regs_clr", 32'(bus.regs_clr), 0);
    check("rst_reset_acc", 32'(bus.reset_accumulation), 0);

    // One filter job: filt_len=3, stride=1
    launch(4'd3, 5'd1, 1'b0);
    check("clr_regs_clr", 32'(bus.regs_clr), 1);
    check("clr_reset_filter", 32'(bus.reset_Filter), 1);
    check("clr_if_rd", 32'(bus.IF_read_start), 1);
    check("clr_filt_rd", 32'(bus.filter_read_start), 1);
    check("clr_start_rd_gen", 32'(bus.start_rd_gen), 0);
    check("clr_busy", 32'(bus.busy), 1);
    check("clr_filt_len", 32'(bus.filt_len), 3);
    check("clr_stride", 32'(bus.stride_len), 1);
    step();
    check("run0_start_rd_gen", 32'(bus.start_rd_gen), 1);
    check("run0_regs_clr", 32'(bus.regs_clr), 0);
    check("run0_if_rd", 32'(bus.IF_read_start), 0);
    check("run0_mux", 32'(bus.filter_mux_sel), 0);
    check("acc_mac0", 32'(bus.reset_accumulation), 0);

    bus.mac_fire = 1'b1;
    step();
    check("run0_start_rd_gen_once", 32'(bus.start_rd_gen), 0);
    check("acc_mac1", 32'(bus.reset_accumulation), 1);
    step();
    check("acc_mac2", 32'(bus.reset_accumulation), 1);
    bus.mac_fire  = 1'b0;
    bus.psum_done = 1'b1;
    step();
    bus.psum_done = 1'b0;
    check("acc_new_window", 32'(bus.reset_accumulation), 0);
    check("win_after_1", 32'(bus.win_count), 1);
    for (int i = 0; i < 3; i++) begin
      bus.psum_done = 1'b1;
      step();
      bus.psum_done = 1'b0;
      step();
    end
    check("win_after_4", 32'(bus.win_count), 4);

    // start during RUN0 must not relatch config or restart
    launch(4'd7, 5'd9, 1'b1);
    check("busy_start_filt_len", 32'(bus.filt_len), 3);
    check("busy_start_stride", 32'(bus.stride_len), 1);
    check("busy_start_regs_clr", 32'(bus.regs_clr), 0);
    check("busy_start_busy", 32'(bus.busy), 1);

    bus.full_done = 1'b1;
    step();
    bus.full_done = 1'b0;
    check("one_done", 32'(bus.done), 1);
    check("one_fin_win", 32'(bus.win_count), 4);
    check("one_fin_usage_ld", 32'(bus.usage_stride_pos_ld), 0);
    step();
    check("one_done_pulse", 32'(bus.done), 0);
    check("one_idle_busy", 32'(bus.busy), 0);
    check("one_idle_win", 32'(bus.win_count), 4);

    // start with zero filter length is ignored
    launch(4'd0, 5'd2, 1'b0);
    check("zero_len_busy", 32'(bus.busy), 0);
    check("zero_len_regs_clr", 32'(bus.regs_clr), 0);
    step();
    check("zero_len_busy2", 32'(bus.busy), 0);
    check("zero_len_filt_len", 32'(bus.filt_len), 3);

    // Two filter job
    launch(4'd5, 5'd2, 1'b1);
    check("two_clr_win_cleared", 32'(bus.win_count), 0);
    check("two_filt_len", 32'(bus.filt_len), 5);
    step();
    check("two_run0_rd_gen", 32'(bus.start_rd_gen), 1);
    bus.psum_done = 1'b1;
    step();
    bus.psum_done = 1'b0;
    check("two_win_pass0", 32'(bus.win_count), 1);
    bus.full_done = 1'b1;
    step();
    bus.full_done = 1'b0;
    check("sw_usage_ld", 32'(bus.usage_stride_pos_ld), 1);
    check("sw_reset_filter", 32'(bus.reset_Filter), 1);
    check("sw_done", 32'(bus.done), 0);
    check("sw_regs_clr", 32'(bus.regs_clr), 0);
    step();
    check("run1_usage_ld", 32'(bus.usage_stride_pos_ld), 0);
    check("run1_reset_filter", 32'(bus.reset_Filter), 0);
    check("run1_rd_gen", 32'(bus.start_rd_gen), 1);
    check("run1_mux", 32'(bus.filter_mux_sel), 1);
    check("run1_acc_first", 32'(bus.reset_accumulation), 0);
    bus.mac_fire = 1'b1;
    step();
    bus.mac_fire = 1'b0;
    check("run1_acc_second", 32'(bus.reset_accumulation), 1);
    check("run1_rd_gen_once", 32'(bus.start_rd_gen), 0);
    // psum_done with full_done: window counted, then FIN
    bus.psum_done = 1'b1;
    bus.full_done = 1'b1;
    step();
    bus.psum_done = 1'b0;
    bus.full_done = 1'b0;
    check("two_done", 32'(bus.done), 1);
    check("two_win_total", 32'(bus.win_count), 2);
    check("two_fin_mux", 32'(bus.filter_mux_sel), 0);
    step();
    check("two_idle_busy", 32'(bus.busy), 0);
    check("two_idle_done", 32'(bus.done), 0);
    // stray datapath strobes in IDLE are ignored
    bus.psum_done = 1'b1;
    step();
    bus.psum_done = 1'b0;
    check("idle_psum_ignored", 32'(bus.win_count), 2);

    // External partial sum at window start
    launch(4'd2, 5'd1, 1'b0);
    step();
    bus.psum_in_valid = 1'b1;
    #1;
`ifdef PSUM_CHAIN_EN
    check("chain_first_acc_in", 32'(bus.accumulate_input_psum), 1);
    check("chain_first_reset_acc", 32'(bus.reset_accumulation), 1);
`else
    check("nochain_acc_in", 32'(bus.accumulate_input_psum), 0);
    check("nochain_reset_acc", 32'(bus.reset_accumulation), 0);
`endif
    bus.mac_fire = 1'b1;
    step();
    bus.mac_fire = 1'b0;
    check("chain_second_acc_in", 32'(bus.accumulate_input_psum), 0);
    check("chain_second_reset_acc", 32'(bus.reset_accumulation), 1);
    bus.psum_in_valid = 1'b0;

    // Reset mid-RUN0 aborts without done
    bus.full_done = 1'b1;
    step();
    bus.full_done = 1'b0;
    step();
    launch(4'd3, 5'd1, 1'b0);
    step();
    bus.psum_done = 1'b1;
    step();
    bus.psum_done = 1'b0;
    check("pre_abort_win", 32'(bus.win_count), 1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_win", 32'(bus.win_count), 0);
    check("abort_filt_len", 32'(bus.filt_len), 0);
    check("abort_rd_gen", 32'(bus.start_rd_gen), 0);
    check("abort_reset_acc", 32'(bus.reset_accumulation), 0);
    step();
    check("abort_no_done", 32'(bus.done), 0);
    check("abort_stay_idle", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
